// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: serialises stereo PCM pairs onto an I2S data line with matching LRCLK.
// Everything runs on clk_clkin; bclk_in is a sampled level whose falling edge enables updates.
module i2s_tx_serializer #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                     clk_clkin,
    input  logic                     reset,
    input  logic                     bclk_in,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] in_left,
    input  logic signed [DATA_W-1:0] in_right,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     bclk_out,
    output logic                     lrclk,
    output logic                     sdata,
    output logic                     underrun
);

    localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0] K_DATA_W = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic                     bclk_d;
    logic                     fall;
    logic                     xfer;
    logic                     load;
    logic                     wrap;
    logic                     hold_full;
    logic signed [DATA_W-1:0] hold_left;
    logic signed [DATA_W-1:0] hold_right;
    logic signed [DATA_W-1:0] active_left;
    logic signed [DATA_W-1:0] active_right;
    logic [CNT_W-1:0]         k;
    logic [CNT_W-1:0]         k_nxt;
    logic [CNT_W-1:0]         k_inc;
    logic                     lrclk_nxt;
    logic                     lrclk_inc;
    logic                     sdata_nxt;
    logic                     sdata_ser;

    // Bit k of a slot carries ch[DATA_W-k] for k in 1..DATA_W; slot bit 0 and the tail are zero.
    function automatic logic slot_bit(input logic signed [DATA_W-1:0] ch,
                                      input logic [CNT_W-1:0]         kk);
        logic [DATA_W-1:0] sh;
        sh = ch;
        sh = sh << (kk - CNT_W'(1));
        if (kk == '0 || kk > K_DATA_W) begin
            return 1'b0;
        end
        return sh[DATA_W-1];
    endfunction

    assign fall      = bclk_d & ~bclk_in;
    assign xfer      = in_valid & in_ready;
    assign wrap      = (k == K_LAST);
    assign k_inc     = wrap ? '0 : k + CNT_W'(1);
    assign lrclk_inc = wrap ? ~lrclk : lrclk;
    assign sdata_ser = slot_bit(lrclk_inc ? active_right : active_left, k_inc);
    assign in_ready  = ~hold_full;
    assign bclk_out  = bclk_d;

    always_ff @(posedge clk_clkin) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        lrclk_nxt = lrclk;
        sdata_nxt = sdata;
        load      = 1'b0;
        case (state)
            IDLE: begin
                k_nxt     = '0;
                lrclk_nxt = 1'b0;
                sdata_nxt = 1'b0;
                if (enable) begin
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (fall) begin
                    k_nxt     = '0;
                    lrclk_nxt = 1'b0;
                    sdata_nxt = 1'b0;
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (fall) begin
                    k_nxt     = k_inc;
                    lrclk_nxt = lrclk_inc;
                    sdata_nxt = sdata_ser;
                    load      = wrap & lrclk;
                end
                if (!enable) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The right slot finishes; the boundary that would start a new frame parks the line.
                if (fall) begin
                    if (wrap && lrclk) begin
                        k_nxt     = '0;
                        lrclk_nxt = 1'b0;
                        sdata_nxt = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        k_nxt     = k_inc;
                        lrclk_nxt = lrclk_inc;
                        sdata_nxt = sdata_ser;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clkin) begin
        if (reset) begin
            bclk_d       <= 1'b0;
            k            <= '0;
            lrclk        <= 1'b0;
            sdata        <= 1'b0;
            underrun     <= 1'b0;
            hold_full    <= 1'b0;
            hold_left    <= '0;
            hold_right   <= '0;
            active_left  <= '0;
            active_right <= '0;
        end else begin
            bclk_d   <= bclk_in;
            k        <= k_nxt;
            lrclk    <= lrclk_nxt;
            sdata    <= sdata_nxt;
            underrun <= load & ~hold_full;
            // A load in the same cycle as a transfer sees the buffer as it was before the transfer.
            if (xfer) begin
                hold_left  <= in_left;
                hold_right <= in_right;
                hold_full  <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (load) begin
                active_left  <= hold_full ? hold_left  : '0;
                active_right <= hold_full ? hold_right : '0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: bclk = clk/4, one record per bclk fall.
`timescale 1ns/1ps
module tb_i2s_tx_serializer;

    logic        clk_clkin = 1'b0;
    logic        reset     = 1'b1;
    logic        bclk_in   = 1'b1;
    logic        enable    = 1'b0;
    logic        in_valid  = 1'b0;
    logic [23:0] in_left   = '0;
    logic [23:0] in_right  = '0;
    logic        in_ready;
    logic        bclk_out;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
    } vec_t;

    vec_t vecs[5];
    bit   q_sd[$];
    bit   q_lr[$];
    bit   q_ur[$];
    bit   cap_on    = 1'b0;
    int   ur_cycles = 0;
    int   n_vec     = 0;
    int   n_err     = 0;
    event fall_ev;

    i2s_tx_serializer #(.DATA_W(24), .SLOT_W(32), .CNT_W(6)) dut (
        .clk_clkin (clk_clkin),
        .reset     (reset),
        .bclk_in   (bclk_in),
        .enable    (enable),
        .in_left   (in_left),
        .in_right  (in_right),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bclk_out  (bclk_out),
        .lrclk     (lrclk),
        .sdata     (sdata),
        .underrun  (underrun)
    );

    always #5 clk_clkin = ~clk_clkin;

    // bclk: 2 clocks low, 2 high; the DUT registers a fall on the edge after bclk_in drops.
    initial begin
        forever begin
            @(posedge clk_clkin);
            #1 bclk_in = 1'b0;
            @(posedge clk_clkin);
            #2;
            if (cap_on) begin
                q_sd.push_back(sdata);
                q_lr.push_back(lrclk);
                q_ur.push_back(underrun);
            end
            -> fall_ev;
            @(posedge clk_clkin);
            #1 bclk_in = 1'b1;
            @(posedge clk_clkin);
        end
    end

    always @(negedge clk_clkin) begin
        ur_cycles <= ur_cycles + (underrun ? 1 : 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int idx, input bit use_lr);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            w = w << 1;
            if (idx + i < q_sd.size()) begin
                w[0] = use_lr ? q_lr[idx + i] : q_sd[idx + i];
            end else begin
                w[0] = 1'bx;
            end
        end
        return w;
    endfunction

    task automatic wait_recs(input int target, input string name);
        int guard;
        guard = 0;
        while (q_sd.size() < target && guard < 3000) begin
            @(fall_ev);
            guard++;
        end
        if (q_sd.size() < target) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got %0d records expected %0d", name, q_sd.size(), target);
        end
    endtask

    // Call only just after a rising edge so the first offered edge is the one observed.
    task automatic push(input logic [23:0] l, input logic [23:0] r, input string name,
                        output int size_at);
        bit done;
        done     = 1'b0;
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk_clkin);
            if (in_ready) begin
                @(posedge clk_clkin);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        size_at  = q_sd.size();
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got in_ready 0 expected 1 within 2000 cycles", name);
        end
    endtask

    initial begin : main
        int base;
        int urb;
        int sz;

        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 32'h52D2D280, 32'h2D2D2D00};
        vecs[1] = '{24'h800000, 24'h7FFFFF, 32'h40000000, 32'h3FFFFF80};
        vecs[2] = '{24'hFFFFFF, 24'h000001, 32'h7FFFFF80, 32'h00000080};
        vecs[3] = '{24'h123456, 24'h000000, 32'h091A2B00, 32'h00000000};
        vecs[4] = '{24'h000000, 24'hFEDCBA, 32'h00000000, 32'h7F6E5D00};

        // reset state
        repeat (3) @(posedge clk_clkin);
        @(negedge clk_clkin);
        chk("rst_sdata",    64'(sdata),    64'd0);
        chk("rst_lrclk",    64'(lrclk),    64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_bclk_out", 64'(bclk_out), 64'd0);
        @(posedge clk_clkin);
        #1 reset = 1'b0;

        // streaming table: back-to-back pushes, frames in order
        base = q_sd.size();
        urb  = ur_cycles;
        push(vecs[0].l, vecs[0].r, "push0", sz);
        @(negedge clk_clkin);
        chk("ready_low_after_push", 64'(in_ready), 64'd0);
        @(fall_ev);
        enable = 1'b1;
        cap_on = 1'b1;
        chk("bclk_out_at_fall", 64'(bclk_out), 64'd0);
        for (int i = 1; i < 5; i++) begin
            push(vecs[i].l, vecs[i].r, $sformatf("push%0d", i), sz);
            chk($sformatf("loads_before_accept%0d", i), 64'((sz - base + 63) / 64), 64'(i));
        end
        wait_recs(base + 320, "stream");
        enable = 1'b0;
        wait_recs(base + 322, "stream_idle");
        cap_on = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("frame%0d_left", i),  64'(word(base + 64 * i, 1'b0)),      64'(vecs[i].exp_l));
            chk($sformatf("frame%0d_right", i), 64'(word(base + 64 * i + 32, 1'b0)), 64'(vecs[i].exp_r));
        end
        chk("frame0_lrclk_left",  64'(word(base, 1'b1)),      64'h0000_0000);
        chk("frame0_lrclk_right", 64'(word(base + 32, 1'b1)), 64'hFFFF_FFFF);
        chk("stream_idle_lr_sd",  64'({q_lr[base + 320], q_sd[base + 320]}), 64'd0);
        chk("stream_underruns",   64'(ur_cycles - urb), 64'd0);

        // enable with empty buffer: one underrun pulse, a silent frame
        base = q_sd.size();
        urb  = ur_cycles;
        @(fall_ev);
        enable = 1'b1;
        cap_on = 1'b1;
        wait_recs(base + 64, "empty");
        enable = 1'b0;
        wait_recs(base + 66, "empty_idle");
        cap_on = 1'b0;
        chk("empty_ur_at_load",  64'(q_ur[base]), 64'd1);
        chk("empty_ur_cycles",   64'(ur_cycles - urb), 64'd1);
        chk("empty_left_bits",   64'(word(base, 1'b0)),      64'd0);
        chk("empty_right_bits",  64'(word(base + 32, 1'b0)), 64'd0);
        chk("empty_lrclk_right", 64'(word(base + 32, 1'b1)), 64'hFFFF_FFFF);

        // push on the very edge of the first frame load with an empty buffer
        base = q_sd.size();
        urb  = ur_cycles;
        @(fall_ev);
        enable = 1'b1;
        cap_on = 1'b1;
        repeat (3) @(posedge clk_clkin);
        #1;
        in_left  = 24'h6B1E3D;
        in_right = 24'h00FF00;
        in_valid = 1'b1;
        @(posedge clk_clkin);
        #1 in_valid = 1'b0;
        chk("coincident_ready_low", 64'(in_ready), 64'd0);
        wait_recs(base + 128, "coincident");
        enable = 1'b0;
        wait_recs(base + 130, "coincident_idle");
        cap_on = 1'b0;
        chk("coincident_ur_at_load", 64'(q_ur[base]), 64'd1);
        chk("coincident_ur_cycles",  64'(ur_cycles - urb), 64'd1);
        chk("coincident_f0_left",    64'(word(base, 1'b0)),      64'd0);
        chk("coincident_f1_left",    64'(word(base + 64, 1'b0)), 64'h358F_1E80);
        chk("coincident_f1_right",   64'(word(base + 96, 1'b0)), 64'h007F_8000);

        // drop enable at left k = 10; right slot completes, no load at the boundary
        base = q_sd.size();
        urb  = ur_cycles;
        @(posedge clk_clkin);
        #1;
        push(24'hC3C3C3, 24'h0F0F0F, "push_drain", sz);
        @(fall_ev);
        enable = 1'b1;
        cap_on = 1'b1;
        wait_recs(base + 11, "drain_k10");
        enable = 1'b0;
        push(24'h111111, 24'h222222, "push_in_drain", sz);
        wait_recs(base + 96, "drain");
        cap_on = 1'b0;
        chk("drain_left",        64'(word(base, 1'b0)),      64'h61E1_E180);
        chk("drain_right",       64'(word(base + 32, 1'b0)), 64'h0787_8780);
        chk("drain_lrclk_right", 64'(word(base + 32, 1'b1)), 64'hFFFF_FFFF);
        chk("drain_idle_sdata",  64'(word(base + 64, 1'b0)), 64'd0);
        chk("drain_idle_lrclk",  64'(word(base + 64, 1'b1)), 64'd0);
        chk("drain_no_load",     64'(in_ready), 64'd0);
        chk("drain_underruns",   64'(ur_cycles - urb), 64'd0);

        // pending pair goes out on re-enable; then reset mid-RUN
        base = q_sd.size();
        urb  = ur_cycles;
        @(fall_ev);
        enable = 1'b1;
        cap_on = 1'b1;
        wait_recs(base + 40, "reenable");
        cap_on = 1'b0;
        chk("reenable_left",     64'(word(base, 1'b0)), 64'h0888_8880);
        chk("reenable_ready",    64'(in_ready), 64'd1);
        chk("reenable_underrun", 64'(ur_cycles - urb), 64'd0);
        @(posedge clk_clkin);
        #1;
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clk_clkin);
        @(negedge clk_clkin);
        chk("midrst_sdata",    64'(sdata),    64'd0);
        chk("midrst_lrclk",    64'(lrclk),    64'd0);
        chk("midrst_underrun", 64'(underrun), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk_clkin);
        #1 reset = 1'b0;
        base = q_sd.size();
        @(fall_ev);
        cap_on = 1'b1;
        wait_recs(base + 40, "post_reset");
        cap_on = 1'b0;
        chk("post_rst_sdata_a", 64'(word(base, 1'b0)),     64'd0);
        chk("post_rst_sdata_b", 64'(word(base + 8, 1'b0)), 64'd0);
        chk("post_rst_lrclk_a", 64'(word(base, 1'b1)),     64'd0);
        chk("post_rst_lrclk_b", 64'(word(base + 8, 1'b1)), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
